// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the instruction-fetch and load/store masters.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous prefetch FIFO with flush.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            empties the FIFO; wins over push and pop in the same cycle
//   push, push_data  write side; push while full is accepted only alongside a pop
//   pop              read side; ignored while empty
//   head_data        oldest entry (meaningless while empty)
//   empty, count     occupancy
module if_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && ((count_q != FullCount) || do_pop);

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + {{PtrW{1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{PtrW{1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_ahb_prefetch.sv
// AHB-Lite instruction-fetch master with prefetch buffer.
// Streams NONSEQ word fetches with pipelined address/data phases, buffers
// responses in a FIFO and hands them to the decoder over valid/ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush_i, flush_pc_i           redirect pulse and target
//   inst_valid_o/inst_ready_i     head handshake; pc_o/inst_o/inst_err_o head data
//   stallreq_o                    high while no instruction is available
//   mst_h*_o                      registered AHB-Lite master outputs
//   mst_hready_i/hresp_i/hrdata_i AHB-Lite slave responses
module if_ahb_prefetch #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]        HPROT_VAL  = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o,
  output logic              inst_err_o,
  output logic              stallreq_o,
  output logic              mst_hsel_o,
  output logic [1:0]        mst_htrans_o,
  output logic [ADDR_W-1:0] mst_haddr_o,
  output logic              mst_hwrite_o,
  output logic [2:0]        mst_hsize_o,
  output logic [2:0]        mst_hburst_o,
  output logic [3:0]        mst_hprot_o,
  output logic              mst_hmastlock_o,
  output logic [31:0]       mst_hwdata_o,
  input  logic              mst_hready_i,
  input  logic              mst_hresp_i,
  input  logic [31:0]       mst_hrdata_i
);
  import ahb_pkg::*;

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntryW = ADDR_W + 33;
  localparam logic [CntW:0] DepthSum = FIFO_DEPTH[CntW:0];

  typedef enum logic [1:0] {StReset, StFetch, StHalt} fetch_state_e;

  fetch_state_e      state_q, state_d;
  logic              epoch_q, epoch_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hsel_q;
  logic [2:0]        hsize_q;
  logic [3:0]        hprot_q;
  logic              addr_epoch_q, addr_epoch_d;
  logic              data_pend_q, data_pend_d;
  logic [ADDR_W-1:0] data_pc_q, data_pc_d;
  logic              data_epoch_q, data_epoch_d;

  logic              addr_pend, data_current, err_first, push, pop, credit, can_issue;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count, cnt_eff;
  logic [CntW:0]     inflight;
  logic [ADDR_W-1:0] base_pc;
  logic [EntryW-1:0] push_data, head;

  assign addr_pend    = (htrans_q == HTRANS_NONSEQ);
  assign data_current = (data_epoch_q == epoch_q);
  // First cycle of a two-cycle ERROR response on a transfer we still care about.
  assign err_first    = data_pend_q && data_current && !mst_hready_i &&
                        (mst_hresp_i == HRESP_ERROR);
  assign push         = data_pend_q && mst_hready_i && data_current && !flush_i;
  assign pop          = inst_valid_o && inst_ready_i;

  // A flush empties the FIFO this edge, so its entries no longer consume credit.
  assign cnt_eff  = flush_i ? '0 : fifo_count;
  assign inflight = {1'b0, cnt_eff} + {{CntW{1'b0}}, addr_pend} + {{CntW{1'b0}}, data_pend_q};
  assign credit   = (inflight < DepthSum);

  assign base_pc   = flush_i ? flush_pc_i : fetch_pc_q;
  assign can_issue = flush_i || (state_q != StHalt);

  always_comb begin
    state_d      = state_q;
    epoch_d      = epoch_q ^ flush_i;
    fetch_pc_d   = base_pc;
    htrans_d     = HTRANS_IDLE;
    haddr_d      = haddr_q;
    addr_epoch_d = addr_epoch_q;
    data_pend_d  = data_pend_q;
    data_pc_d    = data_pc_q;
    data_epoch_d = data_epoch_q;

    if (state_q == StReset) state_d = StFetch;
    if (err_first)          state_d = StHalt;
    if (flush_i)            state_d = StFetch;

    if (err_first) begin
      // Abandon any waited address phase; htrans goes IDLE in the second error cycle.
      htrans_d = HTRANS_IDLE;
    end else if (addr_pend && !mst_hready_i) begin
      // AHB forbids changing a waited address phase, even across a redirect.
      htrans_d = htrans_q;
    end else if (can_issue && credit) begin
      htrans_d     = HTRANS_NONSEQ;
      haddr_d      = base_pc;
      fetch_pc_d   = base_pc + ADDR_W'(4);
      // Tagged at issue so a phase held across a flush keeps the stale epoch.
      addr_epoch_d = epoch_d;
    end

    if (mst_hready_i) begin
      data_pend_d  = addr_pend;
      data_pc_d    = haddr_q;
      data_epoch_d = addr_epoch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReset;
      epoch_q      <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= '0;
      hsel_q       <= 1'b0;
      hsize_q      <= 3'b000;
      hprot_q      <= 4'b0000;
      addr_epoch_q <= 1'b0;
      data_pend_q  <= 1'b0;
      data_pc_q    <= '0;
      data_epoch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      epoch_q      <= epoch_d;
      fetch_pc_q   <= fetch_pc_d;
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      hsel_q       <= (htrans_d == HTRANS_NONSEQ);
      hsize_q      <= HSIZE_WORD;
      hprot_q      <= HPROT_VAL;
      addr_epoch_q <= addr_epoch_d;
      data_pend_q  <= data_pend_d;
      data_pc_q    <= data_pc_d;
      data_epoch_q <= data_epoch_d;
    end
  end

  // Entry layout: {pc, inst, err}; errored fetches carry a zero instruction.
  assign push_data = {data_pc_q, (mst_hresp_i == HRESP_ERROR) ? 32'h0 : mst_hrdata_i,
                      mst_hresp_i};

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid_o = !fifo_empty;
  assign stallreq_o   = fifo_empty;
  assign pc_o         = inst_valid_o ? head[EntryW-1 -: ADDR_W] : '0;
  assign inst_o       = inst_valid_o ? head[32:1] : 32'h0;
  assign inst_err_o   = inst_valid_o && head[0];

  assign mst_hsel_o      = hsel_q;
  assign mst_htrans_o    = htrans_q;
  assign mst_haddr_o     = haddr_q;
  assign mst_hsize_o     = hsize_q;
  assign mst_hprot_o     = hprot_q;
  assign mst_hwrite_o    = 1'b0;
  assign mst_hburst_o    = HBURST_SINGLE;
  assign mst_hmastlock_o = 1'b0;
  assign mst_hwdata_o    = 32'h0;

endmodule

// File: tb/tb_if_ahb_prefetch.sv
// Directed bench for if_ahb_prefetch with a behavioural AHB slave that returns
// mem[a] = a ^ 32'hA5A5_0000 and can insert wait states or an ERROR response.
module tb_if_ahb_prefetch;

  localparam logic [31:0] NONE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = 32'h0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b1;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_err_o;
  logic        stallreq_o;
  logic        hsel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  int checks = 0;
  int errors = 0;

  // Slave configuration, written by the stimulus.
  logic [31:0] err_addr  = NONE;
  logic [31:0] wait_addr = NONE;
  int          wait_n    = 0;

  // Slave data-phase tracking.
  logic        dp_valid = 1'b0;
  logic [31:0] dp_addr  = 32'h0;
  int          dp_cyc   = 0;

  // Observed traffic.
  int          acc_n = 0;
  logic [31:0] del_pc_q[$];
  logic [31:0] del_inst_q[$];

  if_ahb_prefetch #(
    .ADDR_W     (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0),
    .HPROT_VAL  (4'b0010)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_err_o      (inst_err_o),
    .stallreq_o      (stallreq_o),
    .mst_hsel_o      (hsel),
    .mst_htrans_o    (htrans),
    .mst_haddr_o     (haddr),
    .mst_hwrite_o    (hwrite),
    .mst_hsize_o     (hsize),
    .mst_hburst_o    (hburst),
    .mst_hprot_o     (hprot),
    .mst_hmastlock_o (hmastlock),
    .mst_hwdata_o    (hwdata),
    .mst_hready_i    (hready),
    .mst_hresp_i     (hresp),
    .mst_hrdata_i    (hrdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    if (dp_valid) begin
      hrdata = dp_addr ^ 32'hA5A5_0000;
      if (dp_addr == err_addr) begin
        hresp  = 1'b1;
        hready = (dp_cyc == 1);
      end else if (dp_addr == wait_addr) begin
        hready = (dp_cyc >= wait_n);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_cyc   <= 0;
    end else if (hready) begin
      dp_valid <= (htrans == 2'b10);
      dp_addr  <= haddr;
      dp_cyc   <= 0;
    end else begin
      dp_cyc <= dp_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && htrans == 2'b10 && hready) acc_n++;
    if (!rst && inst_valid_o && inst_ready_i) begin
      del_pc_q.push_back(pc_o);
      del_inst_q.push_back(inst_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] del_at(input int i);
    if (i < del_pc_q.size()) return del_pc_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int base;
    int acc0;
    int hits;

    // Reset values.
    repeat (3) step();
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_hsel", hsel, 1'b0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hsize", hsize, 3'b000);
    chk("rst_hprot", hprot, 4'b0000);
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_err", inst_err_o, 1'b0);
    chk("rst_stallreq", stallreq_o, 1'b1);

    // Reset release and zero-wait streaming.
    rst = 1'b0;
    step();
    chk("first_htrans", htrans, 2'b10);
    chk("first_haddr", haddr, 32'h0);
    chk("first_hsel", hsel, 1'b1);
    chk("hsize_word", hsize, 3'b010);
    chk("hprot_val", hprot, 4'b0010);
    chk("hburst", hburst, 3'b000);
    chk("hwrite", hwrite, 1'b0);
    chk("hmastlock", hmastlock, 1'b0);
    chk("hwdata", hwdata, 32'h0);
    step();
    chk("second_haddr", haddr, 32'h4);
    chk("not_yet_valid", inst_valid_o, 1'b0);
    step();
    chk("c3_valid", inst_valid_o, 1'b1);
    chk("c3_pc", pc_o, 32'h0);
    chk("c3_inst", inst_o, 32'hA5A5_0000);
    chk("c3_stallreq", stallreq_o, 1'b0);
    step();
    chk("c4_pc", pc_o, 32'h4);
    step();
    chk("c5_pc", pc_o, 32'h8);
    chk("c5_inst", inst_o, 32'hA5A5_0008);

    // Decoder stall: FIFO fills to exactly its depth, then fetching stops.
    inst_ready_i = 1'b0;
    repeat (20) step();
    chk("stall_idle", htrans, 2'b00);
    chk("stall_head_pc", pc_o, 32'h8);
    chk("stall_buffered", acc_n - del_pc_q.size(), 4);
    acc0 = acc_n;
    repeat (3) step();
    chk("stall_no_issue", acc_n, acc0);
    inst_ready_i = 1'b1;
    repeat (12) step();
    chk("stream_len", del_pc_q.size() >= 12, 1'b1);
    for (int i = 0; i < del_pc_q.size(); i++) begin
      chk($sformatf("stream_pc[%0d]", i), del_pc_q[i], 32'(4 * i));
      chk($sformatf("stream_inst[%0d]", i), del_inst_q[i], 32'(4 * i) ^ 32'hA5A5_0000);
    end

    // Redirect with one address and one data phase in flight.
    flush_i = 1'b1; flush_pc_i = 32'h100;
    step();
    flush_i = 1'b0;
    base = del_pc_q.size();
    chk("redir_htrans", htrans, 2'b10);
    chk("redir_haddr", haddr, 32'h100);
    chk("redir_e1_valid", inst_valid_o, 1'b0);
    step();
    chk("redir_e2_valid", inst_valid_o, 1'b0);
    step();
    chk("redir_e3_valid", inst_valid_o, 1'b1);
    chk("redir_e3_pc", pc_o, 32'h100);
    chk("redir_e3_inst", inst_o, 32'hA5A5_0100);
    repeat (4) step();
    chk("redir_first", del_at(base), 32'h100);
    chk("redir_second", del_at(base + 1), 32'h104);

    // Redirect while the address phase of 0x8 is being held by wait states.
    wait_addr = 32'h4; wait_n = 3;
    flush_i = 1'b1; flush_pc_i = 32'h0;
    step();
    flush_i = 1'b0;
    chk("wait_restart", haddr, 32'h0);
    step();
    step();
    chk("wait_held_a", haddr, 32'h8);
    step();
    flush_i = 1'b1; flush_pc_i = 32'h300;
    step();
    flush_i = 1'b0;
    base = del_pc_q.size();
    chk("wait_held_b", haddr, 32'h8);
    chk("wait_held_trans", htrans, 2'b10);
    step();
    chk("wait_held_c", haddr, 32'h8);
    step();
    chk("wait_new_addr", haddr, 32'h300);
    step();
    step();
    chk("wait_valid", inst_valid_o, 1'b1);
    chk("wait_pc", pc_o, 32'h300);
    repeat (6) step();
    chk("wait_first", del_at(base), 32'h300);
    hits = 0;
    for (int i = base; i < del_pc_q.size(); i++) if (del_pc_q[i] == 32'h8) hits++;
    chk("wait_no_stale", hits, 0);
    wait_addr = NONE;

    // ERROR response on 0xC.
    err_addr = 32'hC;
    flush_i = 1'b1; flush_pc_i = 32'h0;
    step();
    flush_i = 1'b0;
    repeat (4) step();
    chk("err_c1_htrans", htrans, 2'b10);
    chk("err_c1_haddr", haddr, 32'h10);
    step();
    chk("err_c2_idle", htrans, 2'b00);
    step();
    chk("err_valid", inst_valid_o, 1'b1);
    chk("err_pc", pc_o, 32'hC);
    chk("err_flag", inst_err_o, 1'b1);
    chk("err_inst", inst_o, 32'h0);
    repeat (5) step();
    chk("halt_idle", htrans, 2'b00);
    chk("halt_empty", inst_valid_o, 1'b0);
    err_addr = NONE;
    flush_i = 1'b1; flush_pc_i = 32'h200;
    step();
    flush_i = 1'b0;
    chk("resume_htrans", htrans, 2'b10);
    chk("resume_haddr", haddr, 32'h200);
    step();
    step();
    chk("resume_pc", pc_o, 32'h200);
    chk("resume_inst", inst_o, 32'hA5A5_0200);
    chk("resume_err", inst_err_o, 1'b0);

    // Reset mid-stream with a full FIFO.
    inst_ready_i = 1'b0;
    repeat (10) step();
    chk("full_valid", inst_valid_o, 1'b1);
    chk("full_head", pc_o, 32'h200);
    chk("full_idle", htrans, 2'b00);
    rst = 1'b1;
    step();
    chk("mid_rst_htrans", htrans, 2'b00);
    chk("mid_rst_hsel", hsel, 1'b0);
    chk("mid_rst_haddr", haddr, 32'h0);
    chk("mid_rst_hsize", hsize, 3'b000);
    chk("mid_rst_hprot", hprot, 4'b0000);
    chk("mid_rst_valid", inst_valid_o, 1'b0);
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_inst", inst_o, 32'h0);
    chk("mid_rst_stallreq", stallreq_o, 1'b1);
    rst = 1'b0;
    inst_ready_i = 1'b1;
    step();
    chk("restart_htrans", htrans, 2'b10);
    chk("restart_haddr", haddr, 32'h0);
    step();
    step();
    chk("restart_valid", inst_valid_o, 1'b1);
    chk("restart_pc", pc_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
